// File: rtl/arithmetic_unit_if.sv
// ============================================================================
// Module      : arithmetic_unit_if
// Description : Operand, opcode and result/flag bundle for arithmetic_unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface arithmetic_unit_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] op1;
    logic [WIDTH-1:0] op2;
    logic [7:0]       instruction;
    logic [WIDTH-1:0] out;
    logic             carry_flag;
    logic             parity_flag;
    logic             eq_flag;
    logic             gt_flag;

    modport master (
        output op1,
        output op2,
        output instruction,
        input  out,
        input  carry_flag,
        input  parity_flag,
        input  eq_flag,
        input  gt_flag
    );

    modport slave (
        input  op1,
        input  op2,
        input  instruction,
        output out,
        output carry_flag,
        output parity_flag,
        output eq_flag,
        output gt_flag
    );
endinterface

`default_nettype wire

// File: rtl/arithmetic_unit.sv
// ============================================================================
// Module      : arithmetic_unit
// Description : Single-cycle registered ALU with carry/parity/compare flags.
//               The MUL opcode exists only when ARITH_UNIT_MUL_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module arithmetic_unit #(
    parameter int WIDTH = 16
) (
    input  wire                 clk,
    input  wire                 rst,
    arithmetic_unit_if.slave    bus
);
    localparam int c_shw = $clog2(WIDTH);

    localparam logic [7:0] c_op_nop = 8'h00;
    localparam logic [7:0] c_op_add = 8'h01;
    localparam logic [7:0] c_op_sub = 8'h02;
`ifdef ARITH_UNIT_MUL_EN
    localparam logic [7:0] c_op_mul = 8'h03;
`endif
    localparam logic [7:0] c_op_and = 8'h04;
    localparam logic [7:0] c_op_or  = 8'h05;
    localparam logic [7:0] c_op_xor = 8'h06;
    localparam logic [7:0] c_op_inc = 8'h07;
    localparam logic [7:0] c_op_dec = 8'h08;
    localparam logic [7:0] c_op_ror = 8'h09;
    localparam logic [7:0] c_op_rol = 8'h0A;
    localparam logic [7:0] c_op_rsh = 8'h0B;
    localparam logic [7:0] c_op_lsh = 8'h0C;
    localparam logic [7:0] c_op_not = 8'h0D;

    logic [WIDTH-1:0]   r_out;
    logic               r_carry;
    logic               r_parity;
    logic               r_eq;
    logic               r_gt;

    logic [c_shw-1:0]   w_n;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_diff;
    logic [2*WIDTH-1:0] w_ror_ext;
    logic [2*WIDTH-1:0] w_rol_ext;
    logic [WIDTH:0]     w_rsh_ext;
    logic [WIDTH:0]     w_lsh_ext;
    logic               w_exec;
    logic [WIDTH-1:0]   w_res;
    logic               w_carry;
`ifdef ARITH_UNIT_MUL_EN
    logic [2*WIDTH-1:0] w_prod;

    assign w_prod = bus.op1 * bus.op2;
`endif

    assign w_n    = bus.op2[c_shw-1:0];
    assign w_sum  = {1'b0, bus.op1} + {1'b0, bus.op2};
    // Bit WIDTH of the extended difference is the borrow.
    assign w_diff = {1'b0, bus.op1} - {1'b0, bus.op2};

    // Doubled-word tricks give rotates; one guard bit captures the shifted-out bit.
    assign w_ror_ext = {bus.op1, bus.op1} >> w_n;
    assign w_rol_ext = {bus.op1, bus.op1} << w_n;
    assign w_rsh_ext = {bus.op1, 1'b0} >> w_n;
    assign w_lsh_ext = {1'b0, bus.op1} << w_n;

    always_comb begin
        w_exec  = 1'b1;
        w_res   = r_out;
        w_carry = 1'b0;
        case (bus.instruction)
            c_op_nop: w_exec = 1'b0;
            c_op_add: {w_carry, w_res} = w_sum;
            c_op_sub: {w_carry, w_res} = w_diff;
`ifdef ARITH_UNIT_MUL_EN
            c_op_mul: begin
                w_res   = w_prod[WIDTH-1:0];
                w_carry = |w_prod[2*WIDTH-1:WIDTH];
            end
`endif
            c_op_and: w_res = bus.op1 & bus.op2;
            c_op_or:  w_res = bus.op1 | bus.op2;
            c_op_xor: w_res = bus.op1 ^ bus.op2;
            c_op_not: w_res = ~bus.op1;
            c_op_inc: begin
                w_res   = bus.op1 + WIDTH'(1);
                w_carry = &bus.op1;
            end
            c_op_dec: begin
                w_res   = bus.op1 - WIDTH'(1);
                w_carry = ~|bus.op1;
            end
            c_op_ror: begin
                w_res   = w_ror_ext[WIDTH-1:0];
                w_carry = (w_n != '0) && w_ror_ext[WIDTH-1];
            end
            c_op_rol: begin
                w_res   = w_rol_ext[2*WIDTH-1:WIDTH];
                w_carry = (w_n != '0) && w_rol_ext[WIDTH];
            end
            c_op_rsh: begin
                w_res   = w_rsh_ext[WIDTH:1];
                w_carry = w_rsh_ext[0];
            end
            c_op_lsh: begin
                w_res   = w_lsh_ext[WIDTH-1:0];
                w_carry = w_lsh_ext[WIDTH];
            end
            default:  w_exec = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out    <= '0;
            r_carry  <= 1'b0;
            r_parity <= 1'b0;
            r_eq     <= 1'b0;
            r_gt     <= 1'b0;
        end else if (w_exec) begin
            r_out    <= w_res;
            r_carry  <= w_carry;
            r_parity <= ^w_res;
            r_eq     <= (bus.op1 == bus.op2);
            r_gt     <= (bus.op1 > bus.op2);
        end
    end

    assign bus.out         = r_out;
    assign bus.carry_flag  = r_carry;
    assign bus.parity_flag = r_parity;
    assign bus.eq_flag     = r_eq;
    assign bus.gt_flag     = r_gt;

endmodule

`default_nettype wire

// File: tb/tb_arithmetic_unit.sv
// ============================================================================
// Module      : tb_arithmetic_unit
// Description : Directed self-checking bench for arithmetic_unit (WIDTH=16).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_arithmetic_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_total = 0;
    int   n_bad   = 0;

    always #5 clk = ~clk;

    arithmetic_unit_if #(.WIDTH(16)) bus ();

    arithmetic_unit #(.WIDTH(16)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [15:0] e_out, input logic e_c,
                             input logic e_p, input logic e_eq, input logic e_gt);
        check({tag, ".out"},    32'(bus.out),         32'(e_out));
        check({tag, ".carry"},  32'(bus.carry_flag),  32'(e_c));
        check({tag, ".parity"}, 32'(bus.parity_flag), 32'(e_p));
        check({tag, ".eq"},     32'(bus.eq_flag),     32'(e_eq));
        check({tag, ".gt"},     32'(bus.gt_flag),     32'(e_gt));
    endtask

    // Drive on the falling edge, let one rising edge execute, sample 1ns later.
    task automatic do_op(input logic [7:0] instr, input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        bus.instruction = instr;
        bus.op1         = a;
        bus.op2         = b;
        @(posedge clk);
        #1;
    endtask

    logic [15:0] fact_a;
    logic [15:0] fact_p;

    initial begin
        bus.instruction = 8'h01;
        bus.op1         = 16'hFFFF;
        bus.op2         = 16'hFFFF;
        rst             = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", 16'h0000, 0, 0, 0, 0);

        @(negedge clk);
        rst = 1'b0;
        do_op(8'h01, 16'h0002, 16'h0003);
        check_all("first_add", 16'h0005, 0, 0, 0, 0);

        do_op(8'h01, 16'hFFFF, 16'h0001); check_all("add_wrap", 16'h0000, 1, 0, 0, 1);
        do_op(8'h02, 16'h0000, 16'h0001); check_all("sub_borrow", 16'hFFFF, 1, 0, 0, 0);
        do_op(8'h02, 16'h0005, 16'h0003); check_all("sub", 16'h0002, 0, 1, 0, 1);
        do_op(8'h07, 16'hFFFF, 16'h0000); check_all("inc_wrap", 16'h0000, 1, 0, 0, 1);
        do_op(8'h08, 16'h0000, 16'h0000); check_all("dec_wrap", 16'hFFFF, 1, 0, 1, 0);
        do_op(8'h09, 16'h0001, 16'h0001); check_all("ror1", 16'h8000, 1, 1, 1, 0);
        do_op(8'h0C, 16'h8001, 16'h0001); check_all("lsh1", 16'h0002, 1, 1, 0, 1);
        do_op(8'h0B, 16'h00F0, 16'h0004); check_all("rsh4", 16'h000F, 0, 0, 0, 1);
        do_op(8'h0A, 16'h8001, 16'h0004); check_all("rol4", 16'h0018, 0, 0, 0, 1);
        do_op(8'h0A, 16'h1234, 16'h0010); check_all("rol_n0", 16'h1234, 0, 1, 0, 1);
        do_op(8'h0B, 16'h8001, 16'h0020); check_all("rsh_n0", 16'h8001, 0, 0, 0, 1);
        do_op(8'h04, 16'hF0F0, 16'hFF00); check_all("and", 16'hF000, 0, 0, 0, 0);
        do_op(8'h05, 16'h0F00, 16'h00F1); check_all("or", 16'h0FF1, 0, 1, 0, 1);
        do_op(8'h0D, 16'h00FF, 16'h00FF); check_all("not", 16'hFF00, 0, 0, 1, 0);

        do_op(8'h06, 16'h0007, 16'h0003); check_all("xor", 16'h0004, 0, 1, 0, 1);
        do_op(8'h00, 16'hAAAA, 16'hAAAA); check_all("nop_hold", 16'h0004, 0, 1, 0, 1);
        do_op(8'hFF, 16'h0000, 16'h1111); check_all("ff_hold", 16'h0004, 0, 1, 0, 1);
        do_op(8'h0E, 16'h0001, 16'h0000); check_all("0e_hold", 16'h0004, 0, 1, 0, 1);

`ifdef ARITH_UNIT_MUL_EN
        do_op(8'h03, 16'h0100, 16'h0100); check_all("mul_ovf", 16'h0000, 1, 0, 1, 0);
        fact_a = 16'd5;
        fact_p = 16'd1;
        for (int i = 0; i < 8 && fact_a != 16'd1; i++) begin
            do_op(8'h03, fact_a, fact_p);
            fact_p = bus.out;
            check("fact_mul_carry", 32'(bus.carry_flag), 32'd0);
            do_op(8'h08, fact_a, 16'h0000);
            fact_a = bus.out;
        end
        check("fact_product", 32'(fact_p), 32'd120);
        check("fact_end_op1", 32'(fact_a), 32'd1);
`else
        fact_a = 16'd0;
        fact_p = 16'd0;
        do_op(8'h03, 16'h0100, 16'h0100); check_all("mul_off_hold", 16'h0004, 0, 1, 0, 1);
`endif

        // Reset wins over an instruction present at the same edge.
        @(negedge clk);
        rst             = 1'b1;
        bus.instruction = 8'h01;
        bus.op1         = 16'h1234;
        bus.op2         = 16'h1234;
        @(posedge clk);
        #1;
        check_all("reset_mid", 16'h0000, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        do_op(8'h07, 16'h00FE, 16'h0001); check_all("post_reset_inc", 16'h00FF, 0, 0, 0, 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end
endmodule

`default_nettype wire

// File: doc/arithmetic_unit.md
ARITHMETIC_UNIT -- requirements
Module: arithmetic_unit

Interface
REQ-001 Parameter WIDTH, default 16: operand/result width; 16 is the verified value, and any power of two from 8 to 32 SHALL be legal.
REQ-002 clk  input  1  single clock, all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 op1  input  WIDTH  first operand (sole operand for NOT/INC/DEC/ROR/ROL/RSH/LSH).
REQ-005 op2  input  WIDTH  second operand; shift/rotate amount taken from op2[log2(WIDTH)-1:0].
REQ-006 out  output  WIDTH  registered result.
REQ-007 instruction  input  8  opcode.
REQ-008 carry_flag  output  1  registered carry/borrow/overflow/shifted-out bit.
REQ-009 parity_flag  output  1  registered XOR-reduction of the new out (1 = odd count of ones).
REQ-010 eq_flag  output  1  registered (op1 == op2).
REQ-011 gt_flag  output  1  registered (op1 > op2), unsigned.

Function
REQ-012 Latency SHALL be exactly one clock: out and all flags reflect the operands and instruction sampled at the previous rising edge; there SHALL be no combinational input-to-output path.
REQ-013 The opcode map SHALL be NOP=0x00, ADD=0x01, SUB=0x02, MUL=0x03, AND=0x04, OR=0x05, XOR=0x06, INC=0x07, DEC=0x08, ROR=0x09, ROL=0x0A, RSH=0x0B, LSH=0x0C, NOT=0x0D.
REQ-014 NOP and every unlisted opcode (0x0E-0xFF) SHALL hold out and all four flags unchanged.
REQ-015 ADD: out = (op1+op2) mod 2^WIDTH; carry = bit WIDTH of the full sum.
REQ-016 SUB: out = (op1-op2) mod 2^WIDTH; carry = borrow (1 iff op1 < op2).
REQ-017 MUL: out = low WIDTH bits of the unsigned product; carry = 1 iff any upper product bit is nonzero.
REQ-018 AND/OR/XOR: out = bitwise op1 op op2; NOT: out = ~op1; carry = 0 for all four.
REQ-019 INC: out = op1+1, carry = 1 iff op1 = all-ones (out wraps to 0); DEC: out = op1-1, carry = 1 iff op1 = 0 (out wraps to all-ones).
REQ-020 ROR/ROL: rotate op1 right/left by n = op2[log2(WIDTH)-1:0]; carry = last bit rotated across the word boundary (ROR: out[WIDTH-1], ROL: out[0]); when n = 0, out = op1 and carry = 0.
REQ-021 RSH/LSH: logical shift of op1 by n with zero fill; carry = last bit shifted out; when n = 0, out = op1 and carry = 0.
REQ-022 For every non-NOP opcode, parity_flag SHALL be computed from the new out, and eq_flag and gt_flag from op1/op2, independent of the operation.

Reset
REQ-023 When rst = 1 at a rising edge, out = 0 and carry, parity, eq, and gt flags = 0, regardless of instruction.
REQ-024 rst SHALL take priority over any instruction sampled at the same edge; an operation in flight when reset is applied SHALL be discarded.
REQ-025 The first edge after rst deasserts SHALL execute the instruction present at that edge normally.

Configuration
REQ-026 The macro ARITH_UNIT_MUL_EN SHALL control the multiplier.
REQ-027 With ARITH_UNIT_MUL_EN defined, MUL SHALL behave per REQ-017.
REQ-028 Without ARITH_UNIT_MUL_EN, no multiplier SHALL be synthesized and opcode 0x03 SHALL behave as NOP (REQ-014).

Verification
REQ-029 Reset: assert rst for 2 cycles with instruction=ADD, op1=op2=0xFFFF -> out=0x0000 and all flags 0.
REQ-030 Factorial chain with MUL_EN: start with op1=5, op2=1; alternate MUL (feed out->op2) and DEC (feed out->op1) until op1=1 -> final product out=120 (0x0078), carry=0.
REQ-031 Boundaries: ADD 0xFFFF+0x0001 -> out=0x0000, carry=1, parity=0; SUB 0x0000-0x0001 -> 0xFFFF, carry=1; INC 0xFFFF -> 0x0000, carry=1; DEC 0x0000 -> 0xFFFF, carry=1.
REQ-032 Shifts: ROR 0x0001 by 1 -> 0x8000, carry=1; LSH 0x8001 by 1 -> 0x0002, carry=1; RSH 0x00F0 by 4 -> 0x000F, carry=0; any shift with n=0 -> out=op1, carry=0.
REQ-033 Flags/NOP: op1=7, op2=3, XOR -> out=0x0004, parity=1, eq=0, gt=1; then instruction=NOP and 0xFF with changed operands -> all outputs unchanged.
REQ-034 MUL overflow and config: 0x0100*0x0100 -> out=0x0000, carry=1 with MUL_EN; without MUL_EN, opcode 0x03 -> outputs hold.
